// File: rtl/ddr_para_init_seq.sv
// DDR parameter-initialisation sequencer.
// Each init-continue pulse loads one segment of write bursts; after the last
// segment init_done is raised and held until reset.
// Optional feature macro: DDR_INIT_TIMEOUT_EN adds a wr_done watchdog that
// moves the sequencer to a terminal error state and raises err_timeout.
module ddr_para_init_seq #(
  parameter int unsigned NUM_SEG        = 8,
  parameter int unsigned BURSTS_PER_SEG = 16,
  parameter int unsigned ADDR_W         = 30,
  parameter int unsigned BURST_BYTES    = 64,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYC    = 4096
) (
  input  logic                         sys_clk_200M,
  input  logic                         sys_rst_n,
  input  logic                         init_cont_pulse,
  output logic                         wr_req,
  output logic [ADDR_W-1:0]            wr_addr,
  input  logic                         wr_ack,
  input  logic                         wr_done,
  output logic [$clog2(NUM_SEG):0]     seg_idx,
  output logic                         busy,
  output logic                         init_done,
  output logic                         cont_overrun,
  output logic                         err_timeout
);

  localparam int unsigned SegW   = $clog2(NUM_SEG) + 1;
  localparam int unsigned BurstW = (BURSTS_PER_SEG > 1) ? $clog2(BURSTS_PER_SEG) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitDone,
    StWaitCont,
    StDone,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SegW-1:0]     seg_q, seg_d;
  logic                wr_req_q, wr_req_d;
  logic                busy_q, busy_d;
  logic                init_done_q, init_done_d;
  logic                overrun_q, overrun_d;
  logic                burst_done;

`ifdef DDR_INIT_TIMEOUT_EN
  logic [15:0]         to_cnt_q, to_cnt_d;
  logic                err_q, err_d;
`endif

  // Next-state, burst/segment bookkeeping and registered-output next values.
  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    addr_d      = addr_q;
    seg_d       = seg_q;
    wr_req_d    = 1'b0;
    overrun_d   = overrun_q;
    burst_done  = 1'b0;
`ifdef DDR_INIT_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (init_cont_pulse) state_d = StReq;
      end
      StReq: begin
        // First REQ cycle only launches wr_req; ack is sampled once it is visible.
        if (!wr_req_q) begin
          wr_req_d = 1'b1;
        end else if (wr_ack) begin
          if (wr_done) begin
            burst_done = 1'b1;
          end else begin
            state_d = StWaitDone;
`ifdef DDR_INIT_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
        end else begin
          wr_req_d = 1'b1;
        end
      end
      StWaitDone: begin
        if (wr_done) begin
          burst_done = 1'b1;
`ifdef DDR_INIT_TIMEOUT_EN
        end else if (to_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          state_d = StErr;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
`endif
        end
      end
      StWaitCont: begin
        if (init_cont_pulse) state_d = StReq;
      end
      StDone, StErr: begin
        state_d = state_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Address always steps after a burst, including the final one; wrap is silent.
    if (burst_done) begin
      addr_d = addr_q + ADDR_W'(BURST_BYTES);
      if (burst_q < BurstW'(BURSTS_PER_SEG - 1)) begin
        burst_d = burst_q + 1'b1;
        state_d = StReq;
      end else begin
        burst_d = '0;
        seg_d   = seg_q + 1'b1;
        state_d = (seg_q == SegW'(NUM_SEG - 1)) ? StDone : StWaitCont;
      end
    end

    // Pulse is only meaningful in IDLE / WAIT_CONT as seen in the current state.
    if (init_cont_pulse && !(state_q inside {StIdle, StWaitCont})) overrun_d = 1'b1;

    busy_d      = (state_d == StReq) || (state_d == StWaitDone);
    init_done_d = (state_d == StDone);
`ifdef DDR_INIT_TIMEOUT_EN
    err_d       = (state_d == StErr);
`endif
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge sys_clk_200M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      burst_q     <= '0;
      addr_q      <= ADDR_W'(BASE_ADDR);
      seg_q       <= '0;
      wr_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef DDR_INIT_TIMEOUT_EN
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      addr_q      <= addr_d;
      seg_q       <= seg_d;
      wr_req_q    <= wr_req_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      overrun_q   <= overrun_d;
`ifdef DDR_INIT_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign wr_req       = wr_req_q;
  assign wr_addr      = addr_q;
  assign seg_idx      = seg_q;
  assign busy         = busy_q;
  assign init_done    = init_done_q;
  assign cont_overrun = overrun_q;
`ifdef DDR_INIT_TIMEOUT_EN
  assign err_timeout  = err_q;
`else
  assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_para_init_seq.sv
// Self-checking bench for ddr_para_init_seq: table-driven full load plus
// hand-written sequences for back-pressure, ack+done, overrun, reset and timeout.
module tb_ddr_para_init_seq;

  localparam int unsigned NumSeg  = 2;
  localparam int unsigned Bursts  = 2;
  localparam int unsigned AddrW   = 30;
  localparam int unsigned SegW    = $clog2(NumSeg) + 1;

  logic             clk;
  logic             rst_n;
  logic             pulse;
  logic             ack;
  logic             done;
  logic             wr_req;
  logic [AddrW-1:0] wr_addr;
  logic [SegW-1:0]  seg_idx;
  logic             busy;
  logic             init_done;
  logic             cont_overrun;
  logic             err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  ddr_para_init_seq #(
    .NUM_SEG       (NumSeg),
    .BURSTS_PER_SEG(Bursts),
    .ADDR_W        (AddrW),
    .BURST_BYTES   (64),
    .BASE_ADDR     ('h100),
    .TIMEOUT_CYC   (16)
  ) dut (
    .sys_clk_200M   (clk),
    .sys_rst_n      (rst_n),
    .init_cont_pulse(pulse),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_ack         (ack),
    .wr_done        (done),
    .seg_idx        (seg_idx),
    .busy           (busy),
    .init_done      (init_done),
    .cont_overrun   (cont_overrun),
    .err_timeout    (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             p, a, d;
    logic             req;
    logic [AddrW-1:0] addr;
    logic [SegW-1:0]  seg;
    logic             busy, idone, ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic p, a, d, req, input int unsigned addr, input int unsigned seg,
                     input logic bsy, idone, ovr);
    vec_t v;
    v.p = p; v.a = a; v.d = d; v.req = req;
    v.addr = AddrW'(addr); v.seg = SegW'(seg);
    v.busy = bsy; v.idone = idone; v.ovr = ovr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs checked after each edge against an expected record.
  task automatic chk_all(input string tag, input logic req, input int unsigned addr,
                         input int unsigned seg, input logic bsy, idone, ovr, err);
    chk({tag, ".req"},   32'(wr_req),       32'(req));
    chk({tag, ".addr"},  32'(wr_addr),      addr);
    chk({tag, ".seg"},   32'(seg_idx),      seg);
    chk({tag, ".busy"},  32'(busy),         32'(bsy));
    chk({tag, ".idone"}, 32'(init_done),    32'(idone));
    chk({tag, ".ovr"},   32'(cont_overrun), 32'(ovr));
    chk({tag, ".err"},   32'(err_timeout),  32'(err));
  endtask

  // Drive inputs for one cycle, then sample #1 after the edge.
  task automatic step(input logic p, a, d);
    pulse = p; ack = a; done = d;
    @(posedge clk);
    #1;
    pulse = 1'b0; ack = 1'b0; done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pulse = 1'b0; ack = 1'b0; done = 1'b0;
    @(posedge clk);
    #1;
    chk_all("reset", 0, 'h100, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    pulse = 1'b0; ack = 1'b0; done = 1'b0;

    // Full load: p a d | req addr seg busy idone ovr
    add(1, 0, 0, 0, 'h100, 0, 1, 0, 0);
    add(0, 0, 0, 1, 'h100, 0, 1, 0, 0);
    add(0, 1, 0, 0, 'h100, 0, 1, 0, 0);
    add(0, 0, 1, 0, 'h140, 0, 1, 0, 0);
    add(0, 0, 0, 1, 'h140, 0, 1, 0, 0);
    add(0, 1, 0, 0, 'h140, 0, 1, 0, 0);
    add(0, 0, 1, 0, 'h180, 1, 0, 0, 0);
    add(0, 0, 0, 0, 'h180, 1, 0, 0, 0);
    add(0, 0, 0, 0, 'h180, 1, 0, 0, 0);
    add(1, 0, 0, 0, 'h180, 1, 1, 0, 0);
    add(0, 0, 0, 1, 'h180, 1, 1, 0, 0);
    add(0, 1, 0, 0, 'h180, 1, 1, 0, 0);
    add(0, 0, 1, 0, 'h1C0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 'h1C0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 'h1C0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 'h200, 2, 0, 1, 0);
    add(0, 0, 0, 0, 'h200, 2, 0, 1, 0);
    add(1, 0, 0, 0, 'h200, 2, 0, 1, 1);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].p, vecs[i].a, vecs[i].d);
      chk_all($sformatf("v%0d", i), vecs[i].req, 32'(vecs[i].addr), 32'(vecs[i].seg),
              vecs[i].busy, vecs[i].idone, vecs[i].ovr, 1'b0);
    end

    // Ack back-pressure, then same-cycle ack+done, then pulse during WAIT_DONE.
    do_reset();
    step(1, 0, 0);
    step(0, 0, 0);
    chk_all("bp.launch", 1, 'h100, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      chk_all($sformatf("bp.hold%0d", i), 1, 'h100, 0, 1, 0, 0, 0);
    end
    step(0, 1, 1);
    chk_all("ad.idle", 0, 'h140, 0, 1, 0, 0, 0);
    step(0, 0, 0);
    chk_all("ad.next", 1, 'h140, 0, 1, 0, 0, 0);
    step(0, 1, 0);
    chk_all("ov.ack", 0, 'h140, 0, 1, 0, 0, 0);
    step(1, 0, 0);
    chk_all("ov.pulse", 0, 'h140, 0, 1, 0, 1, 0);
    step(0, 0, 1);
    chk_all("ov.segend", 0, 'h180, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk_all($sformatf("ov.nostart%0d", i), 0, 'h180, 1, 0, 0, 1, 0);
    end

    // Reset in the middle of WAIT_DONE for burst 0x140.
    do_reset();
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk_all("rs.pre", 0, 'h140, 0, 1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rs.async", 0, 'h100, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 0);
    chk_all("rs.pulse", 0, 'h100, 0, 1, 0, 0, 0);
    step(0, 0, 0);
    chk_all("rs.restart", 1, 'h100, 0, 1, 0, 0, 0);

    // Watchdog on a missing wr_done.
    do_reset();
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
`ifdef DDR_INIT_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0);
      chk_all($sformatf("to.wait%0d", i), 0, 'h100, 0, 1, 0, 0, 0);
    end
    step(0, 0, 0);
    chk_all("to.err", 0, 'h100, 0, 0, 0, 0, 1);
    step(1, 0, 0);
    chk_all("to.pulse", 0, 'h100, 0, 0, 0, 1, 1);
    step(0, 0, 1);
    chk_all("to.stuck", 0, 'h100, 0, 0, 0, 1, 1);
`else
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk_all("to.off", 0, 'h100, 0, 1, 0, 0, 0);
    step(0, 0, 1);
    chk_all("to.offdone", 1'b0, 'h140, 0, 1, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
